// File: rtl/mux_2x1_pkg.sv
// Shared constants for pipeline datapath selectors (operand B, PC source, write-back).
package mux_2x1_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2x1_en_reg.sv
// Enable-gated register with asynchronous active-low reset to a parameterized value.
module en_reg #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= RESET_VALUE;
      else if (en) q <= d;
   end

endmodule

// File: rtl/mux_2x1.sv
// Word-wide 2:1 selector: combinational y plus an enable-gated registered copy y_q/sel_q.
module mux_2x1
   import mux_2x1_pkg::*;
#(
   parameter int unsigned      WIDTH       = XLEN,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             sel_q
);

   // An unknown sel makes the ternary merge a and b bitwise: matching bits pass,
   // differing bits go X. Synthesis reduces this to a plain mux (non-1 sel -> a).
   assign y = (sel == SEL_B) ? b : a;

   en_reg #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_y_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (y),
      .q     (y_q)
   );

   en_reg #(
      .WIDTH       (1),
      .RESET_VALUE (SEL_A)
   ) u_sel_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (sel),
      .q     (sel_q)
   );

endmodule

// File: tb/tb_mux_2x1.sv
// Directed bench for mux_2x1: scoreboard queue of expected values, immediate-assert checks.
module tb_mux_2x1;

   logic        clk = 1'b0;
   logic        run_clk = 1'b0;
   logic        rst_n = 1'b1;

   logic [31:0] a = '0, b = '0;
   logic        sel = 1'b0, en = 1'b0;
   logic [31:0] y, y_q;
   logic        sel_q;

   logic [7:0]  a8 = '0, b8 = '0;
   logic        sel8 = 1'b0, en8 = 1'b0;
   logic [7:0]  y8, y_q8;
   logic        sel_q8;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   mux_2x1 dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .en(en),
      .y(y), .y_q(y_q), .sel_q(sel_q)
   );

   mux_2x1 #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut8 (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .en(en8),
      .y(y8), .y_q(y_q8), .sel_q(sel_q8)
   );

   always begin
      #5;
      if (run_clk) clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic push(input logic [31:0] exp);
      sb.push_back(exp);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s: got %h, scoreboard empty", tag, obs);
         return;
      end
      exp = sb.pop_front();
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // combinational path, no clock and no reset activity
      a = 32'd10; b = 32'd20; sel = 1'b0; push(32'd10);
      #10; check("comb_sel0", y);
      sel = 1'b1; push(32'd20);
      #10; check("comb_sel1", y);
      sel = 1'b0; a = 32'd1; push(32'd1);
      #10; check("comb_a_follow", y);
      sel = 1'b1; b = 32'd2; push(32'd2);
      #10; check("comb_b_follow", y);

      // asynchronous reset with the clock stopped
      rst_n = 1'b0; push(32'h0); push(32'h0); push(32'h3C);
      #1;
      check("rst_yq", y_q);
      check("rst_selq", {31'b0, sel_q});
      check("rst_yq_w8", {24'b0, y_q8});
      a = 32'hCAFE0001; sel = 1'b0; push(32'hCAFE0001);
      #1; check("comb_in_reset", y);

      // clock runs while reset is held: en ignored
      en = 1'b1; sel = 1'b1; b = 32'h0BAD0BAD;
      run_clk = 1'b1;
      tick(); push(32'h0); check("rst_hold_yq", y_q);
      tick(); push(32'h0); check("rst_hold_selq", {31'b0, sel_q});

      // release mid-cycle, first edge loads
      #2; rst_n = 1'b1;
      a = 32'hDEADBEEF; sel = 1'b0; en = 1'b1;
      push(32'hDEADBEEF); push(32'h0);
      tick();
      check("first_load", y_q);
      check("first_load_selq", {31'b0, sel_q});

      // enable hold
      a = 32'h12345678; push(32'h12345678);
      tick(); check("load_12345678", y_q);
      en = 1'b0; b = 32'hFFFFFFFF; sel = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         push(32'h12345678); check("hold_yq", y_q);
         push(32'hFFFFFFFF); check("hold_y", y);
         push(32'h0);        check("hold_selq", {31'b0, sel_q});
      end

      // mid-cycle reset discards the pending load
      en = 1'b1; b = 32'd5; sel = 1'b1; push(32'd5); push(32'd1);
      tick();
      check("load_5", y_q);
      check("load_5_selq", {31'b0, sel_q});
      #1; b = 32'd7;
      rst_n = 1'b0; push(32'h0); push(32'h0);
      #1;
      check("mid_rst_yq", y_q);
      check("mid_rst_selq", {31'b0, sel_q});
      #1; rst_n = 1'b1;
      push(32'd7); push(32'd1);
      tick();
      check("post_rst_load", y_q);
      check("post_rst_selq", {31'b0, sel_q});

      // 8-bit instance
      a8 = 8'hA5; b8 = 8'h5A; sel8 = 1'b0; en8 = 1'b1; push(32'hA5);
      #1; check("w8_sel0", {24'b0, y8});
      sel8 = 1'b1; push(32'h5A);
      #1; check("w8_sel1", {24'b0, y8});
      sel8 = 1'b0; push(32'hA5);
      #1; check("w8_sel0_again", {24'b0, y8});
      sel8 = 1'b1; push(32'h5A); push(32'h1);
      tick();
      check("w8_yq", {24'b0, y_q8});
      check("w8_selq", {31'b0, sel_q8});

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL sb_drain: got %0d leftover entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
